// File: rtl/suma_if.sv
// suma_if: operand/result bundle between the wide-adder controller and its user
// master drives start/A/B and observes R/cout/busy/done; slave is the adder side
interface suma_if #(
  parameter int M = 4,
  parameter int N = 4
);
  logic start;
  logic [N*M-1:0] A;
  logic [N*M-1:0] B;
  logic [N*M-1:0] R;
  logic cout;
  logic busy;
  logic done;
  modport master(output start, A, B, input R, cout, busy, done);
  modport slave(input start, A, B, output R, cout, busy, done);
endinterface

// File: rtl/suma_secuencial.sv
// suma_secuencial: word-serial N*M-bit adder reusing one M-bit ripple-carry adder over N cycles
// ports: clk, rst (async active-high); bus.start/A/B in; bus.R/cout registered sum and carry,
// bus.busy high in RUN/DONE, bus.done one-cycle result-valid pulse
module suma_secuencial #(
  parameter int M = 4,
  parameter int N = 4
) (
  input logic clk,
  input logic rst,
  suma_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [N*M-1:0] r_a, r_b, r_r;
  logic [IW-1:0] r_idx;
  logic r_c, r_cout;
  logic [M-1:0] w_ai, w_bi, w_sum;
  logic [M:0] w_ch;
  logic w_co;
  // shared M-bit ripple-carry adder fed by the current word and the carry register
  always_comb begin
    w_ai = r_a[r_idx*M +: M];
    w_bi = r_b[r_idx*M +: M];
    w_ch = '0;
    w_sum = '0;
    w_ch[0] = r_c;
    for (int k = 0; k < M; k++) begin
      w_sum[k] = w_ai[k] ^ w_bi[k] ^ w_ch[k];
      w_ch[k+1] = (w_ai[k] & w_bi[k]) | (w_ch[k] & (w_ai[k] ^ w_bi[k]));
    end
    w_co = w_ch[M];
  end
  always_comb begin
    w_next = r_state == IDLE ? (bus.start ? RUN : IDLE) :
             r_state == RUN  ? (r_idx == LAST ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a <= '0;
      r_b <= '0;
      r_r <= '0;
      r_idx <= '0;
      r_c <= 1'b0;
      r_cout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.start) begin
        r_a <= bus.A;
        r_b <= bus.B;
        r_r <= '0;
        r_idx <= '0;
        r_c <= 1'b0;
        r_cout <= 1'b0;
      end else if (r_state == RUN) begin
        r_r[r_idx*M +: M] <= w_sum;
        r_c <= w_co;
        r_idx <= r_idx + 1'b1;
        if (r_idx == LAST) r_cout <= w_co;
      end
    end
  end
  assign bus.R = r_r;
  assign bus.cout = r_cout;
  assign bus.busy = r_state != IDLE;
  assign bus.done = r_state == DONE;
endmodule

// File: tb/tb_suma_secuencial.sv
// tb_suma_secuencial: directed self-checking bench for suma_secuencial with M=4, N=4
module tb_suma_secuencial;
  logic clk, rst;
  int tests, fails;
  suma_if #(.M(4), .N(4)) bus();
  suma_secuencial #(.M(4), .N(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] er,
                        input logic ec, input string tag);
    int n, nb;
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, "_busy_accept"}, 32'(bus.busy), 1);
    chk({tag, "_r_cleared"}, 32'(bus.R), 0);
    n = 0;
    nb = 1;
    while (!bus.done && n < 20) begin
      tick();
      n++;
      nb += int'(bus.busy);
    end
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_busy_cycles"}, nb, 5);
    chk({tag, "_r"}, 32'(bus.R), 32'(er));
    chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
    tick();
    chk({tag, "_idle_busy_done"}, {30'd0, bus.busy, bus.done}, 0);
    chk({tag, "_r_held"}, 32'(bus.R), 32'(er));
  endtask
  initial begin
    int ndone, t1, t2;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    #1;
    chk("reset_outputs", {14'd0, bus.R, bus.cout, bus.busy, bus.done}, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_after_reset", {30'd0, bus.busy, bus.done}, 0);
    run_op(16'h1234, 16'h1111, 16'h2345, 1'b0, "basic");
    bus.A = 16'hFFFF;
    bus.B = 16'h0001;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.A = 16'h0000;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("ripple_r_e%0d", i), 32'(bus.R), 0);
      chk($sformatf("ripple_c_e%0d", i), 32'(dut.r_c), 1);
    end
    tick();
    chk("ripple_done", 32'(bus.done), 1);
    chk("ripple_r", 32'(bus.R), 0);
    chk("ripple_cout", 32'(bus.cout), 1);
    tick();
    run_op(16'h8000, 16'h8000, 16'h0000, 1'b1, "top_carry");
    run_op(16'h7FFF, 16'h0001, 16'h8000, 1'b0, "top_nocarry");
    bus.A = 16'h0F0F;
    bus.B = 16'h0101;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    ndone = 0;
    for (int e = 1; e <= 8; e++) begin
      bus.start = (e == 2 || e == 4);
      if (bus.start) bus.A = 16'hFFFF;
      tick();
      bus.start = 1'b0;
      ndone += int'(bus.done);
      if (e == 4) chk("ignore_r", 32'(bus.R), 32'h1010);
    end
    chk("ignore_one_done", ndone, 1);
    chk("ignore_stays_idle", {30'd0, bus.busy, bus.done}, 0);
    chk("ignore_r_held", 32'(bus.R), 32'h1010);
    bus.A = 16'h1234;
    bus.B = 16'h1111;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("midrst_partial_r", 32'(bus.R), 32'h0045);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {14'd0, bus.R, bus.cout, bus.busy, bus.done}, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_idle", {30'd0, bus.busy, bus.done}, 0);
    run_op(16'h0001, 16'h0001, 16'h0002, 1'b0, "after_rst");
    bus.A = 16'hAAAA;
    bus.B = 16'h5555;
    bus.start = 1'b1;
    tick();
    t1 = -1;
    t2 = -1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (bus.done) begin
        chk($sformatf("b2b_r_t%0d", t), 32'(bus.R), 32'hFFFF);
        chk($sformatf("b2b_cout_t%0d", t), 32'(bus.cout), 0);
        if (t1 < 0) t1 = t; else if (t2 < 0) t2 = t;
      end
      if (t == 5) chk("b2b_r_hold", 32'(bus.R), 32'hFFFF);
      if (t == 6) chk("b2b_r_clear", 32'(bus.R), 0);
    end
    bus.start = 1'b0;
    chk("b2b_first_done", t1, 4);
    chk("b2b_period", t2 - t1, 6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/suma_secuencial.md
# suma_secuencial

Word-serial wide adder controller. It reuses a single M-bit ripple-carry adder (one half adder on bit 0 widened to a full adder with carry-in, full adders above) across N clock cycles to add two N·M-bit operands. It sequences the adder one word per cycle, least-significant word first, and registers the inter-word carry. It sits between the lab's operand registers/switches and result display, and trades latency for an adder N times narrower than a flat N·M-bit `suma`.

## Interface
- `M`, default 4: word width; width of the shared adder.
- `N`, default 4: number of words; N ≥ 2.

- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a new addition; sampled only in IDLE.
- `A`  in  N·M: operand A; captured on the accepting edge.
- `B`  in  N·M: operand B; captured on the accepting edge.
- `R`  out  N·M: sum (mod 2^(N·M)), registered.
- `cout`  out  1: carry out of the most-significant word, registered.
- `busy`  out  1: high in RUN and DONE.
- `done`  out  1: one-cycle pulse; R and cout are valid.

## Operation
- State machine: IDLE, RUN, DONE. Binary-encoded, registered.
- Reset (async, any state): state goes to IDLE. `R`=0, `cout`=0, `busy`=0, `done`=0. Internal operand registers, word index and carry register all clear to 0.
- IDLE with `start`=1 at an edge:
  - capture `A` and `B` into internal registers;
  - clear the word index to 0, the carry register to 0, `R` to 0 and `cout` to 0;
  - move to RUN.
- IDLE with `start`=0: hold all outputs. `R` and `cout` keep the previous result.
- RUN, word index i (0..N-1), each edge:
  - the shared adder computes {c', s} = A_i + B_i + c, where A_i = A[i·M +: M] and c is the carry register;
  - write R[i·M +: M] ← s and c ← c'; increment i;
  - when i = N-1, also set `cout` ← c' and move to DONE.
- DONE: `done`=1 for exactly one cycle, then go unconditionally to IDLE on the next edge.
- `start` is ignored in RUN and DONE. No queuing: a request is lost unless `start` is still high in IDLE.
- Operand inputs `A`/`B` may change freely after the accepting edge; only captured copies are used.
- Arithmetic is unsigned. Overflow is reported only through `cout`; R wraps modulo 2^(N·M).
- Each word slice of `R` is written exactly once per operation. Unwritten upper slices read 0 while RUN is in progress.

## Timing
- Edge 0: `start` sampled high in IDLE. From edge 0 onward, `busy`=1.
- Edges 1..N: words 0..N-1 are processed. After edge N the state is DONE, `done`=1, and `R`/`cout` are final.
- Edge N+1: state returns to IDLE; `done`=0, `busy`=0.
- Latency from the accepting edge to `done`: N cycles. Throughput: one operation per N+2 cycles.
- If `start` is held high continuously, the next accept occurs at edge N+2.
- Reset asserted mid-RUN: the operation is aborted; outputs are immediately 0 without waiting for a clock. After `rst` deasserts, the block is in IDLE and needs a fresh `start`.
- `done` and `busy` are pure state decodes of registered state; no combinational path from inputs to outputs.
- Adder critical path: M full-adder stages plus the carry-register setup.

## Test plan
With M=4, N=4:
- **Basic sum:** A=0x1234, B=0x1111, start pulse → `done` 4 cycles after the accepting edge; R=0x2345, cout=0; `busy` high for exactly 5 cycles.
- **Full carry ripple:** A=0xFFFF, B=0x0001 → R=0x0000, cout=1. After edges 1..3, R reads 0x0000 and the carry register is 1.
- **Top-word carry only:** A=0x8000, B=0x8000 → R=0x0000, cout=1. Then A=0x7FFF, B=0x0001 → R=0x8000, cout=0.
- **Start ignored while busy:** pulse start with A=0x0F0F, B=0x0101. Pulse start again at edges 2 and N with A=0xFFFF → only one `done`; R=0x1010. The block then stays IDLE.
- **Reset mid-op:** assert `rst` asynchronously between edges 2 and 3 → R, cout, busy and done are 0 before the next edge. After release, a start with A=0x0001, B=0x0001 gives R=0x0002.
- **Back-to-back:** hold start high with A=0xAAAA, B=0x5555 → R=0xFFFF, cout=0 each time. `done` pulses every 6 cycles, and `R` holds between operations except for the clear on each accept.
